// File: rtl/address_gen_pkg.sv
// Shared types for the address generator: FSM state encoding and scan-order codes.
package address_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [2:0] MODE_RASTER  = 3'd0;
    localparam logic [2:0] MODE_HMIRROR = 3'd1;
    localparam logic [2:0] MODE_VFLIP   = 3'd2;
    localparam logic [2:0] MODE_ROT180  = 3'd3;

endpackage

// File: rtl/address_gen_pixel_counter.sv
// Row/column up-down counters for a frame walk.
// Ports:
//   clk, n_rst            clock, async active-low reset
//   load_i                load first row/column for the selected scan order
//   step_i                advance one pixel (column first, then row)
//   col_down_i/row_down_i count direction per axis
//   width_i/height_i      frame geometry (held stable for the whole walk)
//   col_end_o             current column is the last of its row
//   last_o                current pixel is the final pixel of the frame
module pixel_counter #(
    parameter int unsigned DIM_W = 13
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             col_down_i,
    input  logic             row_down_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic             col_end_o,
    output logic             last_o
);

    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic             col_end_q, col_end_d;
    logic             last_q, last_d;
    logic [DIM_W-1:0] col_first;
    logic [DIM_W-1:0] col_last;
    logic [DIM_W-1:0] row_first;
    logic [DIM_W-1:0] row_last;
    logic             row_end_d;

    // End flags are derived from the next count so they are registered alongside it.
    always_comb begin
        col_first = col_down_i ? (width_i - DIM_W'(1)) : '0;
        col_last  = col_down_i ? '0 : (width_i - DIM_W'(1));
        row_first = row_down_i ? (height_i - DIM_W'(1)) : '0;
        row_last  = row_down_i ? '0 : (height_i - DIM_W'(1));

        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = col_first;
            row_d = row_first;
        end else if (step_i) begin
            if (col_end_q) begin
                col_d = col_first;
                row_d = row_down_i ? (row_q - DIM_W'(1)) : (row_q + DIM_W'(1));
            end else begin
                col_d = col_down_i ? (col_q - DIM_W'(1)) : (col_q + DIM_W'(1));
            end
        end

        col_end_d = (col_d == col_last);
        row_end_d = (row_d == row_last);
        last_d    = col_end_d && row_end_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q     <= '0;
            row_q     <= '0;
            col_end_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            col_end_q <= col_end_d;
            last_q    <= last_d;
        end
    end

    assign col_end_o = col_end_q;
    assign last_o    = last_q;

endmodule

// File: rtl/address_gen.sv
// Frame-walk address generator: emits one SDRAM byte address and one SRAM
// ring-buffer word address per pixel in raster / h-mirror / v-flip / rotate-180 order.
// Ports:
//   clk, n_rst                          clock, async active-low reset
//   start, abort                        walk control from the transfer controller
//   width, height, mode                 frame geometry and scan order
//   start_address_sdram                 frame base byte address
//   finish_address_sdram                last legal byte address (inclusive)
//   addr_ready / addr_valid             consumer handshake
//   sdram_address, sram_address         current address pair
//   busy, done, error                   walk status
module address_gen
    import address_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned DIM_W      = 13,
    parameter int unsigned BPP        = 4,
    parameter int unsigned SRAM_AW    = 16,
    parameter int unsigned SRAM_DEPTH = 65536
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DIM_W-1:0]   width,
    input  logic [DIM_W-1:0]   height,
    input  logic [ADDR_W-1:0]  start_address_sdram,
    input  logic [ADDR_W-1:0]  finish_address_sdram,
    input  logic [2:0]         mode,
    input  logic               addr_ready,
    output logic               addr_valid,
    output logic [ADDR_W-1:0]  sdram_address,
    output logic [SRAM_AW-1:0] sram_address,
    output logic               busy,
    output logic               done,
    output logic               error
);

    // Wide enough that base + width*height*BPP can never overflow.
    localparam int unsigned EXT_W = ADDR_W + 2 * DIM_W + $clog2(BPP) + 2;

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    width_q, width_d;
    logic [DIM_W-1:0]    height_q, height_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   finish_q, finish_d;
    logic [2:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   col_delta_q, col_delta_d;
    logic [ADDR_W-1:0]   wrap_delta_q, wrap_delta_d;
    logic [ADDR_W-1:0]   sdram_q, sdram_d;
    logic [SRAM_AW-1:0]  sram_q, sram_d;
    logic                addr_valid_q, addr_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                fire;
    logic                col_end;
    logic                last_pix;
    logic                cnt_load;
    logic                cnt_step;
    logic [ADDR_W-1:0]   bpp_a;
    logic [ADDR_W-1:0]   row_stride;
    logic [EXT_W-1:0]    frame_bytes;
    logic [EXT_W-1:0]    frame_end;
    logic [ADDR_W-1:0]   frame_past;
    logic                illegal;

    pixel_counter #(
        .DIM_W (DIM_W)
    ) u_pixel_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_i     (cnt_load),
        .step_i     (cnt_step),
        .col_down_i (mode_q[0]),
        .row_down_i (mode_q[1]),
        .width_i    (width_q),
        .height_i   (height_q),
        .col_end_o  (col_end),
        .last_o     (last_pix)
    );

    assign fire     = addr_valid_q && addr_ready;
    assign cnt_load = (state_q == SETUP);
    assign cnt_step = (state_q == RUN) && fire && !abort;

    // Frame geometry, evaluated on the latched inputs during SETUP.
    always_comb begin
        bpp_a       = ADDR_W'(BPP);
        row_stride  = ADDR_W'(width_q) * bpp_a;
        frame_bytes = EXT_W'(width_q) * EXT_W'(height_q) * EXT_W'(BPP);
        frame_end   = EXT_W'(base_q) + frame_bytes - EXT_W'(1);
        frame_past  = ADDR_W'(EXT_W'(base_q) + frame_bytes);
        illegal     = (width_q == '0) || (height_q == '0) || (mode_q > MODE_ROT180)
                      || (frame_end > EXT_W'(finish_q));
    end

    // Next-state and datapath; registered outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        base_d       = base_q;
        finish_d     = finish_q;
        mode_d       = mode_q;
        col_delta_d  = col_delta_q;
        wrap_delta_d = wrap_delta_q;
        sdram_d      = sdram_q;
        sram_d       = sram_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    width_d  = width;
                    height_d = height;
                    base_d   = start_address_sdram;
                    finish_d = finish_address_sdram;
                    mode_d   = mode;
                    error_d  = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (illegal) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else begin
                    sram_d      = '0;
                    col_delta_d = mode_q[0] ? (ADDR_W'(0) - bpp_a) : bpp_a;
                    // wrap_delta moves from the last pixel of a row to the first of the next.
                    case (mode_q)
                        MODE_HMIRROR: begin
                            sdram_d      = base_q + row_stride - bpp_a;
                            wrap_delta_d = (row_stride << 1) - bpp_a;
                        end
                        MODE_VFLIP: begin
                            sdram_d      = frame_past - row_stride;
                            wrap_delta_d = bpp_a - (row_stride << 1);
                        end
                        MODE_ROT180: begin
                            sdram_d      = frame_past - bpp_a;
                            wrap_delta_d = ADDR_W'(0) - bpp_a;
                        end
                        default: begin
                            sdram_d      = base_q;
                            wrap_delta_d = bpp_a;
                        end
                    endcase
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (fire) begin
                    if (last_pix) begin
                        state_d = FIN;
                    end else begin
                        sdram_d = sdram_q + (col_end ? wrap_delta_q : col_delta_q);
                        sram_d  = (sram_q == SRAM_AW'(SRAM_DEPTH - 1)) ? '0
                                                                       : (sram_q + SRAM_AW'(1));
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        addr_valid_d = (state_d == RUN);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            base_q       <= '0;
            finish_q     <= '0;
            mode_q       <= '0;
            col_delta_q  <= '0;
            wrap_delta_q <= '0;
            sdram_q      <= '0;
            sram_q       <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            base_q       <= base_d;
            finish_q     <= finish_d;
            mode_q       <= mode_d;
            col_delta_q  <= col_delta_d;
            wrap_delta_q <= wrap_delta_d;
            sdram_q      <= sdram_d;
            sram_q       <= sram_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign addr_valid    = addr_valid_q;
    assign sdram_address = sdram_q;
    assign sram_address  = sram_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_address_gen.sv
// Directed bench for address_gen with a scoreboard of expected address pairs.
module tb_address_gen;

    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned DIM_W   = 13;
    localparam int unsigned SRAM_AW = 16;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               start;
    logic               abort;
    logic [DIM_W-1:0]   width;
    logic [DIM_W-1:0]   height;
    logic [ADDR_W-1:0]  start_address_sdram;
    logic [ADDR_W-1:0]  finish_address_sdram;
    logic [2:0]         mode;
    logic               addr_ready;

    logic               addr_valid, busy, done, error;
    logic [ADDR_W-1:0]  sdram_address;
    logic [SRAM_AW-1:0] sram_address;

    logic               valid4, busy4, done4, error4;
    logic [ADDR_W-1:0]  sdram4;
    logic [SRAM_AW-1:0] sram4;

    typedef struct packed {
        logic [ADDR_W-1:0]  sd;
        logic [SRAM_AW-1:0] sr;
        logic [SRAM_AW-1:0] sr4;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    address_gen u_dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .start                (start),
        .abort                (abort),
        .width                (width),
        .height               (height),
        .start_address_sdram  (start_address_sdram),
        .finish_address_sdram (finish_address_sdram),
        .mode                 (mode),
        .addr_ready           (addr_ready),
        .addr_valid           (addr_valid),
        .sdram_address        (sdram_address),
        .sram_address         (sram_address),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    address_gen #(.SRAM_DEPTH(4)) u_dut4 (
        .clk                  (clk),
        .n_rst                (n_rst),
        .start                (start),
        .abort                (abort),
        .width                (width),
        .height               (height),
        .start_address_sdram  (start_address_sdram),
        .finish_address_sdram (finish_address_sdram),
        .mode                 (mode),
        .addr_ready           (addr_ready),
        .addr_valid           (valid4),
        .sdram_address        (sdram4),
        .sram_address         (sram4),
        .busy                 (busy4),
        .done                 (done4),
        .error                (error4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference walk order computed directly from row/column indices.
    task automatic push_model(input int w, input int h, input logic [ADDR_W-1:0] st,
                              input logic [2:0] md);
        int   ri, ci, r, c;
        exp_t e;
        for (int i = 0; i < w * h; i++) begin
            ri    = i / w;
            ci    = i % w;
            r     = md[1] ? (h - 1 - ri) : ri;
            c     = md[0] ? (w - 1 - ci) : ci;
            e.sd  = st + ADDR_W'((r * w + c) * 4);
            e.sr  = SRAM_AW'(i % 65536);
            e.sr4 = SRAM_AW'(i % 4);
            sb.push_back(e);
        end
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0 repeating.
    // abort_k / reset_k: act in the cycle after that many transfers (-1 = never).
    task automatic run_walk(input int w, input int h, input logic [ADDR_W-1:0] st,
                            input logic [ADDR_W-1:0] fin, input logic [2:0] md,
                            input int pat, input int abort_k, input int reset_k);
        longint fe;
        bit     legal;
        bit     ok;
        int     total, xfers, c;
        exp_t   e;
        total = w * h;
        fe    = longint'(st) + longint'(total) * 4 - 1;
        legal = (w != 0) && (h != 0) && (md <= 3'd3) && (fe <= longint'(fin));
        sb.delete();
        if (legal) push_model(w, h, st, md);

        @(posedge clk); #1;
        width                = DIM_W'(w);
        height               = DIM_W'(h);
        start_address_sdram  = st;
        finish_address_sdram = fin;
        mode                 = md;
        addr_ready           = 1'b0;
        abort                = 1'b0;
        start                = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("setup_state", {busy, addr_valid, error}, 3'b100);

        if (!legal) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("illegal_fin", {done, error, addr_valid}, 3'b110);
            @(posedge clk); #1;
            @(negedge clk);
            check("illegal_idle", {busy, done, addr_valid, error}, 4'b0001);
            return;
        end

        xfers = 0;
        c     = 0;
        while (c <= 200) begin
            @(posedge clk); #1;
            addr_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
            abort      = (abort_k == xfers);
            if (reset_k == xfers) begin
                #2;
                n_rst = 1'b0;
                #1;
                check("rst_async", {addr_valid, busy, done, error, sdram_address, sram_address}, 0);
                check("rst_async4", {valid4, busy4, done4, error4, sdram4, sram4}, 0);
                @(negedge clk);
                n_rst      = 1'b1;
                addr_ready = 1'b0;
                sb.delete();
                return;
            end
            @(negedge clk);
            if (c == 0) check("first_valid", addr_valid, 1);
            e = sb[0];
            check("valid", {addr_valid, valid4}, 2'b11);
            check("sdram", sdram_address, e.sd);
            check("sram", sram_address, e.sr);
            check("sram4", sram4, e.sr4);
            if (abort) begin
                @(posedge clk); #1;
                abort      = 1'b0;
                addr_ready = 1'b0;
                @(negedge clk);
                check("abort_idle", {addr_valid, busy, done}, 0);
                ok = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    if (done) ok = 1'b0;
                end
                check("abort_no_done", ok, 1);
                sb.delete();
                return;
            end
            if (addr_ready) begin
                void'(sb.pop_front());
                xfers++;
            end
            if (xfers == total) begin
                @(posedge clk); #1;
                addr_ready = 1'b0;
                @(negedge clk);
                check("done_pulse", {done, addr_valid, busy}, 3'b101);
                @(posedge clk); #1;
                @(negedge clk);
                check("idle_after", {done, busy, addr_valid}, 0);
                return;
            end
            c++;
        end
        check("walk_timeout", xfers, total);
    endtask

    initial begin
        n_rst                = 1'b0;
        start                = 1'b0;
        abort                = 1'b0;
        width                = '0;
        height               = '0;
        start_address_sdram  = '0;
        finish_address_sdram = '0;
        mode                 = '0;
        addr_ready           = 1'b0;
        #3;
        check("reset_outputs", {addr_valid, busy, done, error, sdram_address, sram_address}, 0);
        check("reset_outputs4", {valid4, busy4, done4, error4, sdram4, sram4}, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Scan orders on a 3x2 frame; mode 1 uses the exact-fit finish address.
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd0, 0, -1, -1);
        run_walk(3, 2, 26'h100, 26'h117, 3'd1, 0, -1, -1);
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd2, 0, -1, -1);
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd3, 0, -1, -1);

        // Back-pressure.
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd0, 1, -1, -1);

        // Illegal starts.
        run_walk(3, 2, 26'h100, 26'h116, 3'd0, 0, -1, -1);
        run_walk(0, 2, 26'h100, 26'h1FF, 3'd0, 0, -1, -1);
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd5, 0, -1, -1);
        run_walk(3, 0, 26'h100, 26'h1FF, 3'd5, 0, -1, -1);

        // Larger frames, including single-column and single-row shapes.
        run_walk(5, 4, 26'h2000, 26'h3FFF, 3'd3, 1, -1, -1);
        run_walk(1, 3, 26'h40, 26'h4B, 3'd1, 0, -1, -1);
        run_walk(4, 1, 26'h40, 26'h4F, 3'd2, 0, -1, -1);

        // Abort mid-walk and in the cycle of the final transfer.
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd0, 0, 2, -1);
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd0, 0, 5, -1);

        // Reset mid-walk, then a fresh walk.
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd0, 0, -1, 2);
        run_walk(3, 2, 26'h100, 26'h1FF, 3'd0, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
